// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - state encoding, seconds width and saturating increment for the session sequencer
package game_pkg;

  localparam int SECS_W = 8;

  typedef logic [SECS_W-1:0] secs_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_RESULT    = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    sat_inc = (val >= max_val) ? max_val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/sec_down_counter.sv
// rtl/sec_down_counter.sv - loadable seconds down-counter with tick enable and zero hold
module sec_down_counter
  import game_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  load,
  input  secs_t load_val,
  input  logic  tick,
  output secs_t count,
  output logic  at_one
);

  secs_t count_q;
  secs_t count_d;

  // Clear beats load, load beats a tick; a tick at zero leaves the count alone.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - secs_t'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_one = (count_q == secs_t'(1));

endmodule

// File: rtl/game_session_ctrl.sv
// rtl/game_session_ctrl.sv - multi-round game session sequencer: countdown, timed play, result, next round
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int NUM_GAMES      = 3,
  parameter int NUM_ROUNDS     = 3,
  parameter int ROUND_SECS     = 30,
  parameter int COUNTDOWN_SECS = 3,
  parameter int SCORE_W        = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tick_1s,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              point,
  input  logic                              game_done,
  output logic [NUM_GAMES-1:0]              game_en,
  output logic [2:0]                        state,
  output logic [7:0]                        secs_left,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]   round_idx,
  output logic [SCORE_W-1:0]                round_score,
  output logic [SCORE_W-1:0]                total_score,
  output logic                              session_done
);

  localparam int RIDX_W = $clog2(NUM_ROUNDS + 1);
  localparam secs_t CD_LOAD    = secs_t'(COUNTDOWN_SECS);
  localparam secs_t ROUND_LOAD = secs_t'(ROUND_SECS);
  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(NUM_ROUNDS - 1);
  localparam logic [RIDX_W-1:0] RIDX_ONE   = RIDX_W'(1);

  logic [2:0]           state_q, state_d;
  logic [NUM_GAMES-1:0] game_en_q, game_en_d;
  logic [RIDX_W-1:0]    round_idx_q, round_idx_d;
  logic [SCORE_W-1:0]   round_score_q, round_score_d;
  logic [SCORE_W-1:0]   total_score_q, total_score_d;
  logic                 session_done_q, session_done_d;

  logic                 cnt_clr;
  logic                 cnt_load;
  secs_t                cnt_load_val;
  logic                 cnt_tick;
  secs_t                cnt_value;
  logic                 cnt_at_one;
  logic [NUM_GAMES-1:0] game_onehot;

  // One shared timer serves both the countdown and the play phase.
  sec_down_counter u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (cnt_tick),
    .count    (cnt_value),
    .at_one   (cnt_at_one)
  );

  // Round r plays game (r mod NUM_GAMES).
  always_comb begin
    game_onehot = '0;
    for (int g = 0; g < NUM_GAMES; g++) begin
      if ((int'(round_idx_q) % NUM_GAMES) == g) begin
        game_onehot[g] = 1'b1;
      end
    end
  end

  // Session FSM, score accumulation and timer control; abort overrides everything.
  always_comb begin
    state_d        = state_q;
    game_en_d      = game_en_q;
    round_idx_d    = round_idx_q;
    round_score_d  = round_score_q;
    total_score_d  = total_score_q;
    session_done_d = 1'b0;
    cnt_clr        = 1'b0;
    cnt_load       = 1'b0;
    cnt_load_val   = CD_LOAD;
    cnt_tick       = 1'b0;

    if (abort) begin
      state_d   = ST_IDLE;
      game_en_d = '0;
      cnt_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            state_d       = ST_COUNTDOWN;
            cnt_load      = 1'b1;
            cnt_load_val  = CD_LOAD;
            round_idx_d   = '0;
            round_score_d = '0;
            total_score_d = '0;
          end
        end
        ST_COUNTDOWN: begin
          if (tick_1s) begin
            if (cnt_at_one) begin
              state_d       = ST_PLAY;
              cnt_load      = 1'b1;
              cnt_load_val  = ROUND_LOAD;
              round_score_d = '0;
              game_en_d     = game_onehot;
            end else begin
              cnt_tick = 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (point) begin
            round_score_d = SCORE_W'(sat_inc(32'(round_score_q), SCORE_W));
            total_score_d = SCORE_W'(sat_inc(32'(total_score_q), SCORE_W));
          end
          cnt_tick = tick_1s;
          if ((tick_1s && cnt_at_one) || game_done) begin
            state_d   = ST_RESULT;
            game_en_d = '0;
          end
        end
        ST_RESULT: begin
          if (tick_1s) begin
            if (round_idx_q == LAST_ROUND) begin
              state_d        = ST_FINISH;
              session_done_d = 1'b1;
            end else begin
              state_d      = ST_COUNTDOWN;
              round_idx_d  = round_idx_q + RIDX_ONE;
              cnt_load     = 1'b1;
              cnt_load_val = CD_LOAD;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          game_en_d = '0;
        end
      endcase
    end
  end

  // Registered session state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      game_en_q      <= '0;
      round_idx_q    <= '0;
      round_score_q  <= '0;
      total_score_q  <= '0;
      session_done_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      game_en_q      <= game_en_d;
      round_idx_q    <= round_idx_d;
      round_score_q  <= round_score_d;
      total_score_q  <= total_score_d;
      session_done_q <= session_done_d;
    end
  end

  assign state        = state_q;
  assign game_en      = game_en_q;
  assign secs_left    = cnt_value;
  assign round_idx    = round_idx_q;
  assign round_score  = round_score_q;
  assign total_score  = total_score_q;
  assign session_done = session_done_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// tb/tb_game_session_ctrl.sv - scoreboard bench for game_session_ctrl (8-bit and 4-bit score builds)
module tb_game_session_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CD   = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_RES  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic clk;
  logic rst_n;

  logic       tick_a, start_a, abort_a, point_a, done_a;
  logic [2:0] en_a, st_a;
  logic [7:0] secs_a, rs_a, ts_a;
  logic [1:0] ri_a;
  logic       sd_a;

  logic       tick_b, start_b, abort_b, point_b, done_b;
  logic [2:0] en_b, st_b;
  logic [7:0] secs_b;
  logic [3:0] rs_b, ts_b;
  logic [1:0] ri_b;
  logic       sd_b;

  bit         use4;
  logic [2:0] obs_st, obs_en;
  logic [7:0] obs_secs, obs_rs, obs_ts;
  logic [1:0] obs_ri;
  logic       obs_sd;

  int total;
  int bad;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [7:0] secs;
    logic [2:0] en;
    logic [1:0] ri;
    logic [7:0] rs;
    logic [7:0] ts;
    logic       sd;
  } exp_t;

  exp_t sb[$];

  game_session_ctrl dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1s      (tick_a),
    .start        (start_a),
    .abort        (abort_a),
    .point        (point_a),
    .game_done    (done_a),
    .game_en      (en_a),
    .state        (st_a),
    .secs_left    (secs_a),
    .round_idx    (ri_a),
    .round_score  (rs_a),
    .total_score  (ts_a),
    .session_done (sd_a)
  );

  game_session_ctrl #(.SCORE_W(4)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1s      (tick_b),
    .start        (start_b),
    .abort        (abort_b),
    .point        (point_b),
    .game_done    (done_b),
    .game_en      (en_b),
    .state        (st_b),
    .secs_left    (secs_b),
    .round_idx    (ri_b),
    .round_score  (rs_b),
    .total_score  (ts_b),
    .session_done (sd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_st   = use4 ? st_b   : st_a;
    obs_en   = use4 ? en_b   : en_a;
    obs_secs = use4 ? secs_b : secs_a;
    obs_ri   = use4 ? ri_b   : ri_a;
    obs_rs   = use4 ? {4'd0, rs_b} : rs_a;
    obs_ts   = use4 ? {4'd0, ts_b} : ts_a;
    obs_sd   = use4 ? sd_b   : sd_a;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check_eq({e.tag, ".state"}, 32'(obs_st),   32'(e.st));
    check_eq({e.tag, ".secs"},  32'(obs_secs), 32'(e.secs));
    check_eq({e.tag, ".en"},    32'(obs_en),   32'(e.en));
    check_eq({e.tag, ".round"}, 32'(obs_ri),   32'(e.ri));
    check_eq({e.tag, ".rs"},    32'(obs_rs),   32'(e.rs));
    check_eq({e.tag, ".ts"},    32'(obs_ts),   32'(e.ts));
    check_eq({e.tag, ".done"},  32'(obs_sd),   32'(e.sd));
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then pop and compare.
  task automatic cyc(input string tag, input logic tk, input logic st_in, input logic pt,
                     input logic gd, input logic ab,
                     input logic [2:0] e_st, input logic [7:0] e_secs, input logic [2:0] e_en,
                     input logic [1:0] e_ri, input logic [7:0] e_rs, input logic [7:0] e_ts,
                     input logic e_sd);
    exp_t e;
    exp_t got_e;
    @(negedge clk);
    if (use4) begin
      tick_b = tk; start_b = st_in; point_b = pt; done_b = gd; abort_b = ab;
    end else begin
      tick_a = tk; start_a = st_in; point_a = pt; done_a = gd; abort_a = ab;
    end
    e.tag = tag; e.st = e_st; e.secs = e_secs; e.en = e_en; e.ri = e_ri;
    e.rs = e_rs; e.ts = e_ts; e.sd = e_sd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    check_outputs(got_e);
    tick_a = 0; start_a = 0; point_a = 0; done_a = 0; abort_a = 0;
    tick_b = 0; start_b = 0; point_b = 0; done_b = 0; abort_b = 0;
  endtask

  initial begin
    exp_t rst_e;
    total = 0;
    bad   = 0;
    use4  = 1'b0;
    tick_a = 0; start_a = 0; point_a = 0; done_a = 0; abort_a = 0;
    tick_b = 0; start_b = 0; point_b = 0; done_b = 0; abort_b = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    rst_e.tag = "reset"; rst_e.st = S_IDLE; rst_e.secs = 0; rst_e.en = 0; rst_e.ri = 0;
    rst_e.rs = 0; rst_e.ts = 0; rst_e.sd = 0;
    check_outputs(rst_e);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Round 0: start with a coincident tick, countdown 3-2-1, play entry.
    cyc("idle",     0,0,0,0,0, S_IDLE, 0, 3'b000, 0, 0, 0, 0);
    cyc("start",    1,1,0,0,0, S_CD,   3, 3'b000, 0, 0, 0, 0);
    cyc("cd2",      1,0,0,0,0, S_CD,   2, 3'b000, 0, 0, 0, 0);
    cyc("cd1",      1,0,0,0,0, S_CD,   1, 3'b000, 0, 0, 0, 0);
    cyc("play0",    1,0,0,0,0, S_PLAY, 30, 3'b001, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc("r0pt",   0,0,1,0,0, S_PLAY, 30, 3'b001, 0, 8'(i+1), 8'(i+1), 0);
    for (int i = 0; i < 29; i++)
      cyc("r0tick", 1,0,0,0,0, S_PLAY, 8'(29-i), 3'b001, 0, 5, 5, 0);
    cyc("r0end",    1,0,0,0,0, S_RES,  0, 3'b000, 0, 5, 5, 0);
    cyc("resign",   0,0,1,1,0, S_RES,  0, 3'b000, 0, 5, 5, 0);

    // Round 1: early finish with a point and a tick in the exit cycle.
    cyc("r1cd",     1,0,0,0,0, S_CD,   3, 3'b000, 1, 5, 5, 0);
    cyc("r1cd2",    1,0,0,0,0, S_CD,   2, 3'b000, 1, 5, 5, 0);
    cyc("r1cd1",    1,0,0,0,0, S_CD,   1, 3'b000, 1, 5, 5, 0);
    cyc("play1",    1,0,0,0,0, S_PLAY, 30, 3'b010, 1, 0, 5, 0);
    for (int i = 0; i < 3; i++)
      cyc("r1pt",   0,0,1,0,0, S_PLAY, 30, 3'b010, 1, 8'(i+1), 8'(6+i), 0);
    for (int i = 0; i < 13; i++)
      cyc("r1tick", 1,0,0,0,0, S_PLAY, 8'(29-i), 3'b010, 1, 3, 8, 0);
    cyc("r1done",   1,0,1,1,0, S_RES,  16, 3'b000, 1, 4, 9, 0);

    // Round 2 and session end.
    cyc("r2cd",     1,0,0,0,0, S_CD,   3, 3'b000, 2, 4, 9, 0);
    cyc("r2cd2",    1,0,0,0,0, S_CD,   2, 3'b000, 2, 4, 9, 0);
    cyc("r2cd1",    1,0,0,0,0, S_CD,   1, 3'b000, 2, 4, 9, 0);
    cyc("play2",    1,0,0,0,0, S_PLAY, 30, 3'b100, 2, 0, 9, 0);
    cyc("r2pt",     0,0,1,0,0, S_PLAY, 30, 3'b100, 2, 1, 10, 0);
    cyc("r2pttk",   1,0,1,0,0, S_PLAY, 29, 3'b100, 2, 2, 11, 0);
    cyc("r2done",   0,0,0,1,0, S_RES,  29, 3'b000, 2, 2, 11, 0);
    cyc("finish",   1,0,0,0,0, S_FIN,  29, 3'b000, 2, 2, 11, 1);
    cyc("finhold",  1,0,1,1,0, S_FIN,  29, 3'b000, 2, 2, 11, 0);
    cyc("restart",  0,1,0,0,0, S_CD,   3, 3'b000, 0, 0, 0, 0);
    cyc("re_cd2",   1,0,0,0,0, S_CD,   2, 3'b000, 0, 0, 0, 0);
    cyc("abstart",  0,1,0,0,1, S_IDLE, 0, 3'b000, 0, 0, 0, 0);
    cyc("idletick", 1,0,0,0,0, S_IDLE, 0, 3'b000, 0, 0, 0, 0);

    // 4-bit scores: saturation, abort in PLAY holds scores, abort beats start.
    use4 = 1'b1;
    cyc("b_start",  0,1,0,0,0, S_CD,   3, 3'b000, 0, 0, 0, 0);
    cyc("b_cd2",    1,0,0,0,0, S_CD,   2, 3'b000, 0, 0, 0, 0);
    cyc("b_cd1",    1,0,0,0,0, S_CD,   1, 3'b000, 0, 0, 0, 0);
    cyc("b_play",   1,0,0,0,0, S_PLAY, 30, 3'b001, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc("b_pt",   0,0,1,0,0, S_PLAY, 30, 3'b001, 0,
          (i < 15) ? 8'(i+1) : 8'd15, (i < 15) ? 8'(i+1) : 8'd15, 0);
    cyc("b_abort",  0,0,0,0,1, S_IDLE, 0, 3'b000, 0, 15, 15, 0);
    cyc("b_abst",   0,1,0,0,1, S_IDLE, 0, 3'b000, 0, 15, 15, 0);
    cyc("b_start2", 0,1,0,0,0, S_CD,   3, 3'b000, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a round.
    use4 = 1'b0;
    cyc("c_start",  0,1,0,0,0, S_CD,   3, 3'b000, 0, 0, 0, 0);
    cyc("c_cd2",    1,0,0,0,0, S_CD,   2, 3'b000, 0, 0, 0, 0);
    cyc("c_cd1",    1,0,0,0,0, S_CD,   1, 3'b000, 0, 0, 0, 0);
    cyc("c_play",   1,0,0,0,0, S_PLAY, 30, 3'b001, 0, 0, 0, 0);
    cyc("c_pt",     1,0,1,0,0, S_PLAY, 29, 3'b001, 0, 1, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    rst_e.tag = "async_rst";
    check_outputs(rst_e);
    @(negedge clk) rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
